spi_responder: RTL and testbench
================================

// Module: spi_responder
// PURPOSE
//  SPI target (responder) peripheral for the J1 IO bus, the other end of the bit-banged SPI initiator
//  driven through PIOS. Lets an external host clock bytes in and out of the CPU.
//  Mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit frames; CS held low for multi-byte bursts.
//  Sits beside buart in top; the IO decode in top maps tx/rx data and status onto io_din and io_wr.
// PARAMETERS
//  SYNC_STAGES  3      flops in each pin synchroniser (sck, cs_n, mosi); minimum 2
//  IDLE_BYTE    8'hFF  byte shifted out when no TX byte is pending
// PORTS
//  clk          in   1  system clock (oscillator)
//  reset        in   1  synchronous, active-high reset
//  spi_sck      in   1  host SPI clock, asynchronous to clk
//  spi_cs_n     in   1  host chip select, active low, asynchronous
//  spi_mosi     in   1  host data out, asynchronous
//  spi_miso     out  1  data to host
//  spi_miso_oe  out  1  MISO output enable; 1 only while the frame is selected and active
//  wr           in   1  1-cycle strobe: load tx_data into the TX holding register
//  tx_data      in   8  byte for the host
//  rd           in   1  1-cycle strobe: consume rx_data, clears rx_valid and overrun
//  rx_data      out  8  last complete byte received
//  rx_valid     out  1  rx_data holds an unread byte
//  tx_ready     out  1  TX holding register empty
//  overrun      out  1  sticky: a byte completed while rx_valid=1
//  busy         out  1  CS asserted and frame in progress (state ACTIVE)
// BEHAVIOUR
//  Reset values: spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, overrun=0, busy=0,
//   bit count 0, shifter=IDLE_BYTE.
//  Pins pass through SYNC_STAGES flops. Rise/fall of sck and cs_n are detected on the synced signals.
//   Host SCK must not exceed clk/(2*(SYNC_STAGES+1)); at 30 MHz with 3 stages that is 3.75 MHz.
//  States:
//   IDLE: cs_n high, miso_oe=0. On cs_n fall: load shifter, enter ACTIVE.
//   ACTIVE: miso_oe=1, miso=shifter[7]. On cs_n rise: enter IDLE.
//   WAIT_CS: entered from reset when synced cs_n=0. Ignores sck. On cs_n rise: enter IDLE.
//    This prevents joining a frame partway through.
//  Load rule: shifter <= TX holding register if tx_ready=0 (then tx_ready<=1), else IDLE_BYTE.
//  On each sck rise in ACTIVE:
//   - the synced mosi is shifted into the receive shifter (LSB in).
//   - the bit count increments, 3 bits, wrapping 7->0.
//  On the 8th rise (count 7->0), the byte is complete:
//   - if rx_valid=0 or rd is asserted in the same cycle: rx_data <= byte, rx_valid <= 1.
//   - otherwise: the byte is dropped, rx_data is unchanged, and overrun <= 1.
//   - a reload is flagged as pending.
//  On each sck fall in ACTIVE:
//   - if a reload is pending, run the Load rule and clear the flag.
//   - otherwise shift the transmit shifter left by 1.
//   The next MISO bit is therefore valid before the next rise.
//  Latency: rx_valid rises SYNC_STAGES+1 clk after the 8th sck rise at the pin.
//  cs_n rise mid-byte:
//   - the partial byte is discarded and the bit count goes to 0.
//   - rx_valid is unchanged.
//   - any TX byte already loaded into the shifter is lost.
//  wr with tx_ready=0 overwrites the holding register.
//  wr in the same cycle as a Load:
//   - the Load takes the prior holding content, or IDLE_BYTE if the holding register was empty.
//   - the new byte stays held and tx_ready=0.
//  rd with rx_valid=0: no effect beyond clearing overrun.
//  Reset asserted mid-frame: all state returns to reset values. Next state is WAIT_CS if cs_n is low.
// STRUCTURE
//  Shared package/header:
//   - state encoding constants ST_IDLE, ST_ACTIVE, ST_WAIT_CS.
//   - IDLE_BYTE default.
//   - IO address defines adr_spis_data and adr_spis_stat, next to adr_uart0.
//  Sub-module spi_pin_sync: SYNC_STAGES flop chain plus rise/fall pulse outputs.
//   Instantiated for sck and cs_n; mosi uses the chain only.
//  Core: FSM, 3-bit counter, RX/TX shifters, holding and flag registers.
// TESTING
//  1. One frame: wr 8'hA5; host sends 8'h3C at clk/16 -> MISO bits 1,0,1,0,0,1,0,1;
//     rx_data=8'h3C, rx_valid=1, tx_ready=1.
//  2. Burst of 3 bytes, no wr -> MISO returns FF,FF,FF; rd after each -> no overrun; busy=1 throughout.
//  3. Two bytes 8'h11, 8'h22 with no rd -> rx_data=8'h11, overrun=1; rd -> rx_valid=0, overrun=0.
//  4. cs_n rises after 5 bits -> rx_valid stays 0, count 0; next full frame 8'h5A -> rx_data=8'h5A.
//  5. Reset pulse while cs_n=0 mid-byte -> state WAIT_CS, sck edges ignored, miso_oe=0;
//     cs_n high then low and a frame of 8'h81 -> rx_data=8'h81.
//  6. wr 8'h12 coinciding with the Load at cs_n fall and tx_ready=1 -> byte out is FF, tx_ready=0;
//     next byte out is 8'h12.

Source files
------------

// File: rtl/spi_responder_pkg.sv
// ============================================================================
// Module  : spi_responder_pkg
// Brief   : Shared state encoding, idle byte and IO addresses for the SPI responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_t;

  localparam logic [7:0] C_IDLE_BYTE = 8'hFF;

  // J1 IO map: SPI responder registers sit next to the UART
  localparam logic [15:0] adr_uart0     = 16'h1000;
  localparam logic [15:0] adr_spis_data = 16'h1010;
  localparam logic [15:0] adr_spis_stat = 16'h1020;

endpackage

`default_nettype wire

// File: rtl/spi_responder_pin_sync.sv
// ============================================================================
// Module  : spi_pin_sync
// Brief   : Multi-flop pin synchroniser with registered rise/fall pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_pin_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  // Chain resets low so a released cs_n shows up as a rise after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[SYNC_STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_responder.sv
// ============================================================================
// Module  : spi_responder
// Brief   : SPI mode-0 target for the J1 IO bus, MSB first, 8-bit frames
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 3,
  parameter logic [7:0] IDLE_BYTE   = C_IDLE_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       wr,
  input  logic [7:0] tx_data,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_ready,
  output logic       overrun,
  output logic       busy
);

  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_unused_sync;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (spi_sck),
    .o_sync (w_sck_sync),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_pin  (spi_cs_n),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  assign w_unused_sync = w_sck_sync ^ w_cs_sync;

  // MOSI needs the level only; same depth keeps it aligned with the sck edges
  logic [SYNC_STAGES-1:0] r_mosi_chain;
  logic                   w_mosi_sync;

  always_ff @(posedge clk) begin
    if (reset) r_mosi_chain <= '0;
    else       r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], spi_mosi};
  end

  assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];

  state_t     r_state, w_state_nxt;
  logic       w_load, w_shift, w_bit, w_abort;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_hold;
  logic       r_tx_ready;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_reload_pend;
  logic [7:0] w_rx_byte;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT_CS;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_bit       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_bit = w_sck_rise;
          if (w_sck_fall) begin
            w_load  = r_reload_pend;
            w_shift = ~r_reload_pend;
          end
        end
      end
      ST_WAIT_CS: begin
        if (w_cs_rise) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rx_byte = {r_rx_shift, w_mosi_sync};

  // Later assignments deliberately win: wr over the load's tx_ready set,
  // byte completion over rd's rx_valid clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 7'd0;
      r_tx_shift    <= IDLE_BYTE;
      r_tx_hold     <= 8'd0;
      r_tx_ready    <= 1'b1;
      r_rx_data     <= 8'd0;
      r_rx_valid    <= 1'b0;
      r_overrun     <= 1'b0;
      r_reload_pend <= 1'b0;
    end else begin
      if (rd) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
      if (w_load) begin
        r_tx_shift    <= r_tx_ready ? IDLE_BYTE : r_tx_hold;
        r_tx_ready    <= 1'b1;
        r_reload_pend <= 1'b0;
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      if (wr) begin
        r_tx_hold  <= tx_data;
        r_tx_ready <= 1'b0;
      end
      if (w_abort) begin
        r_bit_cnt     <= 3'd0;
        r_reload_pend <= 1'b0;
      end
      if (w_bit) begin
        r_rx_shift <= w_rx_byte[6:0];
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_reload_pend <= 1'b1;
          if (!r_rx_valid || rd) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign busy        = (r_state == ST_ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = busy & r_tx_shift[7];
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = r_tx_ready;
  assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_responder.sv
// ============================================================================
// Module  : tb_spi_responder
// Brief   : Directed scoreboard bench for spi_responder driven by a mode-0 host
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spi_responder;

  logic       clk;
  logic       reset;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       wr, rd;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_ready, overrun, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] act_miso;
  event       ev_miso;

  spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr          (wr),
    .tx_data     (tx_data),
    .rd          (rd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_ready    (tx_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX monitor: each new rx_valid rise is scored against the next expected byte
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_v) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got %0h expected none", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      prev_v = rx_valid;
    end
  end

  // MISO monitor: scores each byte the host assembled
  initial begin
    forever begin
      @(ev_miso);
      if (exp_miso.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso_unexpected: got %0h expected none", act_miso);
      end else begin
        check("miso_byte", act_miso, exp_miso.pop_front());
      end
    end
  end

  task automatic xfer(input logic [7:0] mo, input logic [7:0] exp_mi);
    logic [7:0] cap;
    cap = 8'h00;
    exp_miso.push_back(exp_mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      repeat (8) @(negedge clk);
      check("miso_oe", spi_miso_oe, 1);
      check("busy", busy, 1);
      cap[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
    act_miso = cap;
    -> ev_miso;
  endtask

  task automatic bits(input logic [7:0] mo, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = mo[i];
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_wr(input logic [7:0] b);
    tx_data = b;
    wr      = 1'b1;
    @(negedge clk);
    wr      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wr = 1'b0; rd = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single frame with a pending TX byte
    do_wr(8'hA5);
    check("t1_tx_ready_held", tx_ready, 0);
    exp_rx.push_back(8'h3C);
    cs_low();
    xfer(8'h3C, 8'hA5);
    cs_high();
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_tx_ready", tx_ready, 1);
    check("t1_busy_idle", busy, 0);
    do_rd();
    check("t1_rx_cleared", rx_valid, 0);

    // 2: three-byte burst, idle bytes out, rd after each
    cs_low();
    exp_rx.push_back(8'hC3); xfer(8'hC3, 8'hFF); do_rd();
    exp_rx.push_back(8'h7E); xfer(8'h7E, 8'hFF); do_rd();
    exp_rx.push_back(8'h01); xfer(8'h01, 8'hFF); do_rd();
    check("t2_overrun", overrun, 0);
    cs_high();

    // 3: overrun on unread byte
    exp_rx.push_back(8'h11);
    cs_low();
    xfer(8'h11, 8'hFF);
    xfer(8'h22, 8'hFF);
    cs_high();
    check("t3_rx_data", rx_data, 8'h11);
    check("t3_overrun", overrun, 1);
    check("t3_rx_valid", rx_valid, 1);
    do_rd();
    check("t3_rd_valid", rx_valid, 0);
    check("t3_rd_overrun", overrun, 0);

    // 4: aborted partial byte then a clean frame
    cs_low();
    bits(8'hF0, 5);
    cs_high();
    check("t4_partial_valid", rx_valid, 0);
    exp_rx.push_back(8'h5A);
    cs_low();
    xfer(8'h5A, 8'hFF);
    cs_high();
    check("t4_rx_data", rx_data, 8'h5A);
    do_rd();

    // 5: reset mid-frame lands in WAIT_CS and ignores sck
    cs_low();
    bits(8'hFF, 4);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_miso_oe", spi_miso_oe, 0);
    bits(8'hFF, 8);
    check("t5_ignored_valid", rx_valid, 0);
    check("t5_ignored_oe", spi_miso_oe, 0);
    cs_high();
    exp_rx.push_back(8'h81);
    cs_low();
    xfer(8'h81, 8'hFF);
    cs_high();
    check("t5_rx_data", rx_data, 8'h81);
    do_rd();

    // 6: wr coincident with the cs_n-fall load
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    do_wr(8'h12);
    check("t6_tx_ready", tx_ready, 0);
    repeat (6) @(negedge clk);
    exp_rx.push_back(8'h00);
    xfer(8'h00, 8'hFF);
    do_rd();
    exp_rx.push_back(8'hE7);
    xfer(8'hE7, 8'h12);
    cs_high();
    check("t6_tx_ready_after", tx_ready, 1);
    do_rd();

    repeat (4) @(negedge clk);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
